// File: rtl/core_wb_arbiter_if.sv
// Bundle between the producer channels, the write-back arbiter and the
// register file write ports. The arbiter uses the slave modport; the
// producer/register-file side uses the master modport.
interface core_wb_arbiter_if #(
  parameter int REG_W  = 5,
  parameter int WORD_W = 32
);
  localparam int NUM_GPREGS = 1 << REG_W;

  // producer channels, index 0 has the highest priority
  logic [3:0]             in_valid;
  logic [3:0]             in_ready;
  logic [3:0][REG_W-1:0]  in_rd;
  logic [3:0][WORD_W-1:0] in_value;

  // register file write ports
  logic [REG_W-1:0]  wr_r_a, wr_r_b, wr_r_c;
  logic              wr_enable_a, wr_enable_b, wr_enable_c;
  logic [WORD_W-1:0] wr_value_a, wr_value_b, wr_value_c;

  // registers with a write still in flight
  logic [NUM_GPREGS-1:0] pending;

  modport slave (
    input  in_valid, in_rd, in_value,
    output in_ready,
    output wr_r_a, wr_r_b, wr_r_c,
    output wr_enable_a, wr_enable_b, wr_enable_c,
    output wr_value_a, wr_value_b, wr_value_c,
    output pending
  );

  modport master (
    output in_valid, in_rd, in_value,
    input  in_ready,
    input  wr_r_a, wr_r_b, wr_r_c,
    input  wr_enable_a, wr_enable_b, wr_enable_c,
    input  wr_value_a, wr_value_b, wr_value_c,
    input  pending
  );
endinterface

// File: rtl/core_wb_arbiter.sv
// Write-back arbiter: four producer channels, each buffered in a DEPTH-entry
// FIFO, feed up to three register file write ports per cycle from registered
// outputs. Heads are scanned 0..3; a head whose rd matches an earlier pick in
// the same cycle waits, so same-register writes retire in priority order.
// Also exports the pending-write scoreboard for the issue stage.
// Optional feature: define WB_BYPASS_EN to let a beat arriving at an empty
// FIFO compete for a port in its handshake cycle.
module core_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int REG_W  = 5,
  parameter int WORD_W = 32
) (
  input logic               clk,
  input logic               rst,
  core_wb_arbiter_if.slave  bus
);
  localparam int NCH        = 4;
  localparam int NPORT      = 3;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int NUM_GPREGS = 1 << REG_W;

  logic [REG_W-1:0]  mem_rd  [NCH][DEPTH];
  logic [WORD_W-1:0] mem_val [NCH][DEPTH];
  logic [PTR_W-1:0]  rptr    [NCH];
  logic [PTR_W-1:0]  wptr    [NCH];
  logic [CNT_W-1:0]  count   [NCH];

  logic [NCH-1:0]    ready, accept, cand_valid, sel, pop, push;
  logic [REG_W-1:0]  cand_rd  [NCH];
  logic [WORD_W-1:0] cand_val [NCH];

  logic [NPORT-1:0]  nxt_en, out_en;
  logic [REG_W-1:0]  nxt_rd  [NPORT];
  logic [REG_W-1:0]  out_rd  [NPORT];
  logic [WORD_W-1:0] nxt_val [NPORT];
  logic [WORD_W-1:0] out_val [NPORT];
  logic [1:0]        nsel;
  logic              hit;

  logic [NUM_GPREGS-1:0] pend;
  logic [PTR_W-1:0]      off;

  // Handshake: ready is a pure function of the FIFO count; R0 beats are
  // acknowledged but never stored.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ready[i]  = count[i] != CNT_W'(DEPTH);
      accept[i] = bus.in_valid[i] && ready[i] && (bus.in_rd[i] != '0);
    end
  end

  assign bus.in_ready = ready;

  // Candidate per channel: the FIFO head, or the incoming beat when bypassing.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every output gets a default before any conditional override, so no latch is inferred.
      cand_valid[i] = count[i] != '0;
      cand_rd[i]    = mem_rd[i][rptr[i]];
      cand_val[i]   = mem_val[i][rptr[i]];
`ifdef WB_BYPASS_EN
      if (count[i] == '0 && accept[i]) begin
        cand_valid[i] = 1'b1;
        cand_rd[i]    = bus.in_rd[i];
        cand_val[i]   = bus.in_value[i];
      end
`endif
    end
  end

  // Priority scan: pick up to three candidates with distinct rd, packed onto ports a, b, c.
  always_comb begin
    // NOTE: blocking assignments here so later iterations see earlier picks; flops use <= only.
    sel    = '0;
    nsel   = '0;
    hit    = 1'b0;
    nxt_en = '0;
    for (int p = 0; p < NPORT; p++) begin
      nxt_rd[p]  = '0;
      nxt_val[p] = '0;
    end
    for (int i = 0; i < NCH; i++) begin
      hit = 1'b0;
      for (int j = 0; j < NCH; j++) begin
        if (j < i && sel[j] && cand_rd[j] == cand_rd[i]) hit = 1'b1;
      end
      if (cand_valid[i] && nsel != 2'(NPORT) && !hit) begin
        sel[i]        = 1'b1;
        nxt_en[nsel]  = 1'b1;
        nxt_rd[nsel]  = cand_rd[i];
        nxt_val[nsel] = cand_val[i];
        nsel          = nsel + 2'd1;
      end
    end
  end

  // A selected FIFO head pops; a beat selected straight from the input never enters the FIFO.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pop[i]  = sel[i] && (count[i] != '0);
      push[i] = accept[i] && !(sel[i] && (count[i] == '0));
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        rptr[i]  <= '0;
        wptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PTR_W'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // FIFO storage writes.
  // NOTE: storage is not reset; entry validity comes solely from rptr/count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem_rd[i][wptr[i]]  <= bus.in_rd[i];
        mem_val[i][wptr[i]] <= bus.in_value[i];
      end
    end
  end

  // Output stage, reloaded every cycle; unused ports carry zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en <= '0;
      for (int p = 0; p < NPORT; p++) begin
        out_rd[p]  <= '0;
        out_val[p] <= '0;
      end
    end else begin
      out_en <= nxt_en;
      for (int p = 0; p < NPORT; p++) begin
        out_rd[p]  <= nxt_rd[p];
        out_val[p] <= nxt_val[p];
      end
    end
  end

  assign bus.wr_enable_a = out_en[0];
  assign bus.wr_enable_b = out_en[1];
  assign bus.wr_enable_c = out_en[2];
  assign bus.wr_r_a      = out_rd[0];
  assign bus.wr_r_b      = out_rd[1];
  assign bus.wr_r_c      = out_rd[2];
  assign bus.wr_value_a  = out_val[0];
  assign bus.wr_value_b  = out_val[1];
  assign bus.wr_value_c  = out_val[2];

  // Scoreboard: every live FIFO entry plus every enabled output port marks its rd.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        off = PTR_W'(j) - rptr[i];
        if (CNT_W'(off) < count[i]) pend[mem_rd[i][j]] = 1'b1;
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      if (out_en[p]) pend[out_rd[p]] = 1'b1;
    end
  end

  assign bus.pending = pend;

endmodule
